// File: rtl/test_sequencer.sv
// test_sequencer: steps a testbench through clear, stimulus, pipeline drain and result capture.
// Build option TEST_SEQUENCER_ERROR_STOP_EN ends stimulus early once the scoreboard reports an error.
//
// state | meaning
// IDLE  | waiting for i_start; testbench frozen, not in reset
// CLR   | testbench held in reset for RESET_CYCLES cycles
// RUN   | stimulus enabled for the latched vector count
// DRAIN | stimulus off for latched DUT delay + 2 cycles
// DONE  | result snapshots and pass flag held until i_ack
module test_sequencer #(
   parameter int CTR_WIDTH    = 32,
   parameter int RESET_CYCLES = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_start,
   input  logic                 i_abort,
   input  logic                 i_ack,
   input  logic [CTR_WIDTH-1:0] i_num_vectors,
   input  logic [CTR_WIDTH-1:0] i_dut_delay,
   input  logic [CTR_WIDTH-1:0] i_error_ctr,
   input  logic [CTR_WIDTH-1:0] i_data_ctr,
   output logic                 o_tb_reset,
   output logic                 o_tb_enable,
   output logic                 o_tb_freeze,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_pass,
   output logic                 o_early_stop,
   output logic [CTR_WIDTH-1:0] o_res_errors,
   output logic [CTR_WIDTH-1:0] o_res_data
);

   localparam int CNT_W = CTR_WIDTH + 1;
   localparam logic [CNT_W-1:0] CLR_LOAD = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLR   = 3'd1,
      RUN   = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t               state, state_nx;
   logic [CNT_W-1:0]     cnt, cnt_nx;
   logic [CTR_WIDTH-1:0] num_lat, num_nx;
   logic [CTR_WIDTH-1:0] dly_lat, dly_nx;
   logic [CNT_W-1:0]     run_load;
   logic [CNT_W-1:0]     drain_load;

   // Down-counters load length-1 and leave the state on terminal count zero;
   // the extra bit lets delay+2 and the all-ones vector count fit without wrap.
   assign run_load   = {1'b0, num_lat} - ONE;
   assign drain_load = {1'b0, dly_lat} + ONE;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      num_nx   = num_lat;
      dly_nx   = dly_lat;
      case (state)
         IDLE: begin
            if (i_start && !i_abort) begin
               state_nx = CLR;
               cnt_nx   = CLR_LOAD;
               num_nx   = i_num_vectors;
               dly_nx   = i_dut_delay;
            end
         end
         CLR: begin
            if (i_abort) begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end else if (cnt == '0) begin
               if (num_lat == '0) begin
                  state_nx = DRAIN;
                  cnt_nx   = drain_load;
               end else begin
                  state_nx = RUN;
                  cnt_nx   = run_load;
               end
            end else begin
               cnt_nx = cnt - ONE;
            end
         end
         RUN: begin
            if (i_abort) begin
               state_nx = IDLE;
               cnt_nx   = '0;
`ifdef TEST_SEQUENCER_ERROR_STOP_EN
            end else if (i_error_ctr != '0) begin
               state_nx = DRAIN;
               cnt_nx   = drain_load;
`endif
            end else if (cnt == '0) begin
               state_nx = DRAIN;
               cnt_nx   = drain_load;
            end else begin
               cnt_nx = cnt - ONE;
            end
         end
         DRAIN: begin
            if (i_abort) begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end else if (cnt == '0) begin
               state_nx = DONE;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt - ONE;
            end
         end
         DONE: begin
            if (i_abort || i_ack) state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   // Outputs are registered from the next state so they line up with the state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         num_lat      <= '0;
         dly_lat      <= '0;
         o_tb_reset   <= 1'b0;
         o_tb_enable  <= 1'b0;
         o_tb_freeze  <= 1'b1;
         o_busy       <= 1'b0;
         o_done       <= 1'b0;
         o_pass       <= 1'b0;
         o_res_errors <= '0;
         o_res_data   <= '0;
      end else begin
         state       <= state_nx;
         cnt         <= cnt_nx;
         num_lat     <= num_nx;
         dly_lat     <= dly_nx;
         o_tb_reset  <= (state_nx == CLR);
         o_tb_enable <= (state_nx == RUN);
         o_tb_freeze <= (state_nx == IDLE) || (state_nx == CLR) || (state_nx == DONE);
         o_busy      <= (state_nx == CLR) || (state_nx == RUN) || (state_nx == DRAIN);
         o_done      <= (state_nx == DONE);
         if ((state != DONE) && (state_nx == DONE)) begin
            o_res_errors <= i_error_ctr;
            o_res_data   <= i_data_ctr;
            o_pass       <= (i_error_ctr == '0);
         end else if (state_nx != DONE) begin
            o_pass <= 1'b0;
         end
      end
   end

`ifdef TEST_SEQUENCER_ERROR_STOP_EN
   logic early_stop_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         early_stop_q <= 1'b0;
      end else if ((state == RUN) && !i_abort && (i_error_ctr != '0)) begin
         early_stop_q <= 1'b1;
      end else if (state_nx == IDLE) begin
         early_stop_q <= 1'b0;
      end
   end

   assign o_early_stop = early_stop_q;
`else
   assign o_early_stop = 1'b0;
`endif

endmodule

// File: tb/tb_test_sequencer.sv
// Directed bench for test_sequencer: phase lengths, snapshots, abort/reset handling and
// a narrow instance run at its all-ones vector count and delay.
module tb_test_sequencer;

   localparam int W = 32;

`ifdef TEST_SEQUENCER_ERROR_STOP_EN
   localparam bit STOP_EN = 1'b1;
`else
   localparam bit STOP_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic         i_start, i_abort, i_ack;
   logic [W-1:0] i_num_vectors, i_dut_delay, i_error_ctr, i_data_ctr;
   logic         o_tb_reset, o_tb_enable, o_tb_freeze, o_busy, o_done, o_pass, o_early_stop;
   logic [W-1:0] o_res_errors, o_res_data;

   logic         s_start, s_abort, s_ack;
   logic [7:0]   s_num, s_dly, s_err, s_data;
   logic         s_tb_reset, s_tb_enable, s_tb_freeze, s_busy, s_done, s_pass, s_early;
   logic [7:0]   s_res_errors, s_res_data;

   logic [6:0]   flags;
   int           n_checks = 0;
   int           n_errors = 0;

   always #5 clk = ~clk;

   assign flags = {o_tb_reset, o_tb_enable, o_tb_freeze, o_busy, o_done, o_pass, o_early_stop};

   test_sequencer #(.CTR_WIDTH(W), .RESET_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .i_start(i_start), .i_abort(i_abort), .i_ack(i_ack),
      .i_num_vectors(i_num_vectors), .i_dut_delay(i_dut_delay),
      .i_error_ctr(i_error_ctr), .i_data_ctr(i_data_ctr),
      .o_tb_reset(o_tb_reset), .o_tb_enable(o_tb_enable), .o_tb_freeze(o_tb_freeze),
      .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass), .o_early_stop(o_early_stop),
      .o_res_errors(o_res_errors), .o_res_data(o_res_data)
   );

   test_sequencer #(.CTR_WIDTH(8), .RESET_CYCLES(4)) dut8 (
      .clk(clk), .reset(reset), .i_start(s_start), .i_abort(s_abort), .i_ack(s_ack),
      .i_num_vectors(s_num), .i_dut_delay(s_dly),
      .i_error_ctr(s_err), .i_data_ctr(s_data),
      .o_tb_reset(s_tb_reset), .o_tb_enable(s_tb_enable), .o_tb_freeze(s_tb_freeze),
      .o_busy(s_busy), .o_done(s_done), .o_pass(s_pass), .o_early_stop(s_early),
      .o_res_errors(s_res_errors), .o_res_data(s_res_data)
   );

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Called on a falling edge; returns phase lengths counted at falling edges until done.
   task automatic run_seq(input logic [W-1:0] num, input logic [W-1:0] dly, input int err_at,
                          input bit perturb, output int rst_c, output int en_c, output int dr_c);
      int cyc;
      rst_c = 0; en_c = 0; dr_c = 0; cyc = 0;
      i_num_vectors = num;
      i_dut_delay   = dly;
      i_start       = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      while (!o_done && cyc < 2000) begin
         if (o_tb_reset) rst_c++;
         if (o_tb_enable) en_c++;
         if (o_busy && !o_tb_enable && !o_tb_reset) dr_c++;
         if (err_at != 0 && en_c == err_at) i_error_ctr = 1;
         if (perturb && en_c == 1) begin
            i_num_vectors = 3;
            i_dut_delay   = 0;
            i_start       = 1'b1;
         end
         @(negedge clk);
         cyc++;
      end
      i_start = 1'b0;
      check_val("done_reached", o_done, 1);
   endtask

   task automatic do_ack();
      i_ack = 1'b1;
      @(negedge clk);
      i_ack = 1'b0;
      check_val("ack_idle_flags", flags, 7'b0010000);
   endtask

   initial begin
      int r, e, d, cnt, cyc;
      reset = 1'b1;
      i_start = 0; i_abort = 0; i_ack = 0;
      i_num_vectors = 0; i_dut_delay = 0; i_error_ctr = 0; i_data_ctr = 0;
      s_start = 0; s_abort = 0; s_ack = 0; s_num = 0; s_dly = 0; s_err = 0; s_data = 0;
      repeat (3) @(negedge clk);
      check_val("rst_flags", flags, 7'b0010000);
      check_val("rst_res", {o_res_errors, o_res_data}, 64'h0);
      reset = 1'b0;
      @(negedge clk);

      // num=10 delay=2, inputs disturbed mid-run
      i_data_ctr = 32'h55;
      run_seq(10, 2, 0, 1'b1, r, e, d);
      check_val("a_rst_cycles", r, 4);
      check_val("a_en_cycles", e, 10);
      check_val("a_drain_cycles", d, 4);
      check_val("a_done_flags", flags, 7'b0010110);
      check_val("a_res_data", o_res_data, 32'h55);
      check_val("a_res_errors", o_res_errors, 0);
      i_data_ctr = 32'h99;
      repeat (3) @(negedge clk);
      check_val("a_done_hold", flags, 7'b0010110);
      check_val("a_snap_hold", o_res_data, 32'h55);
      do_ack();

      // empty run goes straight from CLR to DRAIN
      run_seq(0, 0, 0, 1'b0, r, e, d);
      check_val("b_rst_cycles", r, 4);
      check_val("b_en_cycles", e, 0);
      check_val("b_drain_cycles", d, 2);
      check_val("b_done_flags", flags, 7'b0010110);
      do_ack();

      // scoreboard error during the sixth RUN cycle
      i_data_ctr = 7;
      run_seq(100, 1, 6, 1'b0, r, e, d);
      check_val("c_en_cycles", e, STOP_EN ? 6 : 100);
      check_val("c_drain_cycles", d, 3);
      check_val("c_res_errors", o_res_errors, 1);
      check_val("c_done_flags", flags, {6'b001010, STOP_EN});
      do_ack();
      i_error_ctr = 0;

      // abort in RUN cycle 3, then restart
      i_num_vectors = 20; i_dut_delay = 0; i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      cnt = 0; cyc = 0;
      while (cyc < 100) begin
         if (o_tb_enable) cnt++;
         if (cnt == 3) break;
         @(negedge clk);
         cyc++;
      end
      check_val("d_reached_run3", cnt, 3);
      i_abort = 1'b1;
      @(negedge clk);
      i_abort = 1'b0;
      check_val("d_abort_flags", flags, 7'b0010000);
      check_val("d_snap_hold", {o_res_errors, o_res_data}, {32'd1, 32'd7});
      run_seq(2, 0, 0, 1'b0, r, e, d);
      check_val("d_rst_cycles", r, 4);
      check_val("d_en_cycles", e, 2);
      check_val("d_drain_cycles", d, 2);
      do_ack();

      // reset in DRAIN, reset+start, start+abort
      i_num_vectors = 1; i_dut_delay = 5; i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      cyc = 0;
      while (!(o_busy && !o_tb_enable && !o_tb_reset) && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      check_val("e_in_drain", o_busy && !o_tb_enable && !o_tb_reset, 1);
      reset = 1'b1;
      @(negedge clk);
      check_val("e_rst_flags", flags, 7'b0010000);
      check_val("e_rst_res", {o_res_errors, o_res_data}, 64'h0);
      i_start = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      i_start = 1'b0;
      check_val("e_rst_beats_start", flags, 7'b0010000);
      i_start = 1'b1;
      i_abort = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      i_abort = 1'b0;
      check_val("e_start_abort", flags, 7'b0010000);
      @(negedge clk);
      check_val("e_still_idle", flags, 7'b0010000);

      // 8-bit instance at all-ones count and delay: 255 enables, 257 drain cycles
      s_num = 8'hFF; s_dly = 8'hFF; s_data = 8'h3C; s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      r = 0; e = 0; d = 0; cyc = 0;
      while (!s_done && cyc < 2000) begin
         if (s_tb_reset) r++;
         if (s_tb_enable) e++;
         if (s_busy && !s_tb_enable && !s_tb_reset) d++;
         @(negedge clk);
         cyc++;
      end
      check_val("w_done", s_done, 1);
      check_val("w_rst_cycles", r, 4);
      check_val("w_en_cycles", e, 255);
      check_val("w_drain_cycles", d, 257);
      check_val("w_res", {s_pass, s_res_data}, {1'b1, 8'h3C});
      s_ack = 1'b1;
      @(negedge clk);
      s_ack = 1'b0;
      check_val("w_ack", {s_done, s_busy, s_tb_freeze}, 3'b001);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
